// File: rtl/unary_pkg.sv
// Shared types and width helpers for the unary arithmetic datapath.
// Imported by the stream encoder and its bit generator.
package unary_pkg;

  typedef enum logic {
    UNARY_THERM = 1'b0,
    UNARY_DIST  = 1'b1
  } unary_mode_e;

  typedef enum logic {
    ENC_IDLE = 1'b0,
    ENC_EMIT = 1'b1
  } enc_state_e;

  localparam int UNARY_DEF_WIDTH = 32;

  // A count must hold 0..n inclusive, hence n+1 codes.
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/unary_bit_gen.sv
// Next-bit / next-accumulator function for thermometer and
// distributed unary streams; purely combinational.
module unary_bit_gen
  import unary_pkg::*;
#(
  parameter int INPUT_WIDTH = UNARY_DEF_WIDTH,
  parameter int COUNT_WIDTH = count_width(INPUT_WIDTH)
) (
  input  unary_mode_e            mode,
  input  logic [COUNT_WIDTH-1:0] val,
  input  logic [COUNT_WIDTH-1:0] idx,
  input  logic [COUNT_WIDTH-1:0] acc,
  output logic                   bit_next,
  output logic [COUNT_WIDTH-1:0] acc_next
);

  localparam logic [COUNT_WIDTH:0] W_S =
    (COUNT_WIDTH+1)'(INPUT_WIDTH);
  localparam logic [COUNT_WIDTH-1:0] W_C =
    COUNT_WIDTH'(INPUT_WIDTH);

  logic [COUNT_WIDTH:0] sum;
  logic                 wrap;

  assign sum  = {1'b0, acc} + {1'b0, val};
  assign wrap = (sum >= W_S);

  always_comb begin
    bit_next = 1'b0;
    acc_next = acc;
    unique case (mode)
      UNARY_THERM: begin
        bit_next = (idx < val);
      end
      UNARY_DIST: begin
        // acc stays below INPUT_WIDTH, so the wrapped value fits
        bit_next = wrap;
        acc_next = acc + val - (wrap ? W_C : '0);
      end
      default: begin
        bit_next = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/unary_stream_encoder.sv
// Serialises a binary count into an INPUT_WIDTH-bit unary stream,
// one bit per cycle, with valid/ready input and stall control.
module unary_stream_encoder
  import unary_pkg::*;
#(
  parameter int INPUT_WIDTH = UNARY_DEF_WIDTH,
  parameter int COUNT_WIDTH = count_width(INPUT_WIDTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [COUNT_WIDTH-1:0] in_value,
  input  logic                   in_mode,
  output logic                   in_ready,
  input  logic                   stall,
  output logic                   bit_out,
  output logic                   bit_valid,
  output logic                   busy,
  output logic                   done
);

  localparam logic [COUNT_WIDTH-1:0] W_C =
    COUNT_WIDTH'(INPUT_WIDTH);
  localparam logic [COUNT_WIDTH-1:0] LAST =
    COUNT_WIDTH'(INPUT_WIDTH - 1);
  localparam logic [COUNT_WIDTH-1:0] ONE =
    COUNT_WIDTH'(1);

  enc_state_e             state;
  enc_state_e             state_nx;
  unary_mode_e            mode;
  unary_mode_e            cur_mode;
  logic [COUNT_WIDTH-1:0] val;
  logic [COUNT_WIDTH-1:0] idx;
  logic [COUNT_WIDTH-1:0] acc;
  logic [COUNT_WIDTH-1:0] sat_val;
  logic [COUNT_WIDTH-1:0] cur_val;
  logic [COUNT_WIDTH-1:0] cur_idx;
  logic [COUNT_WIDTH-1:0] cur_acc;
  logic [COUNT_WIDTH-1:0] gen_acc;
  logic                   gen_bit;
  logic                   fire;
  logic                   last;

  assign sat_val  = (in_value > W_C) ? W_C : in_value;
  assign in_ready = (state == ENC_IDLE);
  assign busy     = (state == ENC_EMIT);

  // The accept edge also emits bit 0, so a done-cycle accept
  // continues the bitstream with no bubble.
  always_comb begin
    state_nx = state;
    fire     = 1'b0;
    last     = 1'b0;
    cur_val  = val;
    cur_mode = mode;
    cur_idx  = idx;
    cur_acc  = acc;
    unique case (state)
      ENC_IDLE: begin
        if (in_valid) begin
          fire     = 1'b1;
          cur_val  = sat_val;
          cur_mode = unary_mode_e'(in_mode);
          cur_idx  = '0;
          cur_acc  = '0;
          state_nx = ENC_EMIT;
        end
      end
      ENC_EMIT: begin
        fire = !stall;
      end
      default: begin
        state_nx = ENC_IDLE;
      end
    endcase
    if (fire && (cur_idx == LAST)) begin
      last     = 1'b1;
      state_nx = ENC_IDLE;
    end
  end

  unary_bit_gen #(
    .INPUT_WIDTH (INPUT_WIDTH),
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_gen (
    .mode     (cur_mode),
    .val      (cur_val),
    .idx      (cur_idx),
    .acc      (cur_acc),
    .bit_next (gen_bit),
    .acc_next (gen_acc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ENC_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      val       <= '0;
      mode      <= UNARY_THERM;
      idx       <= '0;
      acc       <= '0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      bit_valid <= fire;
      done      <= last;
      if (fire) begin
        bit_out <= gen_bit;
        val     <= cur_val;
        mode    <= cur_mode;
        idx     <= cur_idx + ONE;
        acc     <= gen_acc;
      end else if (state == ENC_IDLE) begin
        bit_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_unary_stream_encoder.sv
// Directed self-checking bench for unary_stream_encoder.
// Expected bits come from closed-form floor(k*v/W) counts.
module tb_unary_stream_encoder;

  localparam int W  = 32;
  localparam int CW = $clog2(W + 1);

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic [CW-1:0] in_value;
  logic          in_mode;
  logic          in_ready;
  logic          stall;
  logic          bit_out;
  logic          bit_valid;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  unary_stream_encoder #(
    .INPUT_WIDTH (W),
    .COUNT_WIDTH (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_value  (in_value),
    .in_mode   (in_mode),
    .in_ready  (in_ready),
    .stall     (stall),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got,
                       input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_ones(input int v, input bit m,
                                  input int n);
    if (m) return (n * v) / W;
    return (n < v) ? n : v;
  endfunction

  function automatic int exp_bit(input int v, input bit m,
                                 input int k);
    return exp_ones(v, m, k + 1) - exp_ones(v, m, k);
  endfunction

  task automatic start(input int v, input bit m);
    @(negedge clk);
    check("ready_pre", in_ready, 1);
    in_valid = 1'b1;
    in_value = CW'(v);
    in_mode  = m;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic idle_check();
    @(negedge clk);
    check("idle_valid", bit_valid, 0);
    check("idle_done", done, 0);
    check("idle_bit", bit_out, 0);
    check("idle_busy", busy, 0);
    check("idle_ready", in_ready, 1);
  endtask

  // Called just after an accept edge; returns in the done cycle.
  task automatic expect_stream(input int v, input bit m,
                               input int st_at, input int st_len,
                               input int last_len);
    int vs, k, cyc, scnt, gaps, ones;
    bit applied;
    vs = (v > W) ? W : v;
    k = 0; cyc = 0; scnt = 0; gaps = 0; ones = 0;
    applied = 1'b0;
    while (k < W && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (applied) begin
        gaps++;
        check("stall_valid", bit_valid, 0);
        check("stall_done", done, 0);
      end else begin
        check("valid", bit_valid, 1);
        check("bit", bit_out, exp_bit(vs, m, k));
        check("done", done, (k == W - 1) ? 1 : 0);
        if (bit_out) ones++;
        check("ones", ones, exp_ones(vs, m, k + 1));
        if (k == W - 1) check("ready_at_done", in_ready, 1);
        else check("busy", busy, 1);
        k++;
      end
      if (scnt == 0 && !applied) begin
        if (st_len > 0 && k == st_at + 1) scnt = st_len;
        else if (last_len > 0 && k == W - 1) scnt = last_len;
      end
      applied = (scnt > 0);
      if (scnt > 0) scnt--;
      stall = applied;
    end
    stall = 1'b0;
    check("length", k, W);
    check("gaps", gaps, st_len + last_len);
  endtask

  initial begin
    int k, cyc;
    reset    = 1'b0;
    stall    = 1'b0;
    in_valid = 1'b0;
    in_value = '0;
    in_mode  = 1'b0;
    #3;
    check("rst_valid", bit_valid, 0);
    check("rst_bit", bit_out, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    check("rel_ready", in_ready, 1);

    stall = 1'b1;
    idle_check();
    idle_check();
    stall = 1'b0;

    start(5, 1'b0);
    expect_stream(5, 1'b0, -1, 0, 0);
    idle_check();

    start(16, 1'b1);
    expect_stream(16, 1'b1, -1, 0, 0);
    idle_check();

    start(8, 1'b1);
    expect_stream(8, 1'b1, -1, 0, 0);
    idle_check();

    start(13, 1'b1);
    expect_stream(13, 1'b1, 10, 3, 2);
    idle_check();

    start(20, 1'b0);
    expect_stream(20, 1'b0, 10, 3, 2);
    idle_check();

    start(0, 1'b0);
    expect_stream(0, 1'b0, -1, 0, 0);
    start(0, 1'b1);
    expect_stream(0, 1'b1, -1, 0, 0);
    start(40, 1'b0);
    expect_stream(40, 1'b0, -1, 0, 0);
    start(40, 1'b1);
    expect_stream(40, 1'b1, -1, 0, 0);
    idle_check();

    // back-to-back with in_valid held high
    @(negedge clk);
    in_valid = 1'b1;
    in_value = CW'(12);
    in_mode  = 1'b1;
    @(posedge clk);
    #1 in_value = CW'(20);
    expect_stream(12, 1'b1, -1, 0, 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    expect_stream(20, 1'b1, -1, 0, 0);
    idle_check();

    // asynchronous abort at bit 17
    start(20, 1'b1);
    k = 0; cyc = 0;
    while (k < 18 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bit_valid) k++;
    end
    check("abort_reach", k, 18);
    #2 reset = 1'b0;
    #1;
    check("abort_valid", bit_valid, 0);
    check("abort_bit", bit_out, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    check("abort_ready", in_ready, 1);
    repeat (3) begin
      @(negedge clk);
      check("abort_nodone", done, 0);
      check("abort_novalid", bit_valid, 0);
    end
    start(3, 1'b0);
    expect_stream(3, 1'b0, -1, 0, 0);
    idle_check();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/unary_stream_encoder.md
Name: unary_stream_encoder

Overview:
Upstream source stage for the unary arithmetic units, including the unary square-root unit. It accepts one binary count per transaction and serialises it into an INPUT_WIDTH-bit unary bitstream, one bit per cycle, on a bit/valid pair.
Two orderings are supported. Thermometer mode emits all ones first. Distributed mode spreads the ones evenly, so every prefix of the stream is a proportional estimate of the final value, which downstream bounds-tracking units rely on.
The block has a simple valid/ready input handshake, a stall input, and a done pulse.

Parameters:
INPUT_WIDTH, 32, stream length in bits per transaction.
COUNT_WIDTH, $clog2(INPUT_WIDTH+1), width of binary count values.

Ports:
clk  input  1  clock.
reset  input  1  asynchronous, active-low reset.
in_valid  input  1  in_value/in_mode are valid.
in_value  input  COUNT_WIDTH  binary number of ones to emit; saturated to INPUT_WIDTH.
in_mode  input  1  0 = thermometer, 1 = distributed.
in_ready  output  1  block can accept a transaction (state IDLE).
stall  input  1  downstream pause; freezes emission.
bit_out  output  1  unary data bit (drives downstream a).
bit_valid  output  1  bit_out valid this cycle (drives downstream ready).
busy  output  1  transaction in progress.
done  output  1  one-cycle pulse coincident with the last valid bit.

Behaviour:
- Reset: clk is the clock; reset is asynchronous, active-low.
  - State goes to IDLE; value, mode, idx and acc clear to 0.
  - bit_out=0, bit_valid=0, done=0, busy=0. in_ready is 1 once reset is released.
- FSM states: IDLE, EMIT.
  - in_ready = (state==IDLE), combinational. busy = (state==EMIT).
- Accept: on a clk edge with in_valid && in_ready, latch the following and go to EMIT.
  - val = min(in_value, INPUT_WIDTH); mode = in_mode; idx=0; acc=0.
  - in_valid while not ready is ignored; there is no queuing.
- EMIT, on each edge with stall==0:
  - Register bit_out and set bit_valid=1; idx <= idx+1.
  - Thermometer: bit = (idx < val).
  - Distributed: s = acc + val (COUNT_WIDTH+1 bits); bit = (s >= INPUT_WIDTH); acc <= bit ? s-INPUT_WIDTH : s.
  - Invariant: the count of ones after k bits equals floor(k*val/INPUT_WIDTH), exact at k=INPUT_WIDTH.
- EMIT, on each edge with stall==1:
  - bit_valid <= 0; bit_out, idx and acc hold; done stays 0.
- Termination: on the edge that emits bit index INPUT_WIDTH-1, set done <= 1 and state <= IDLE.
  - The last bit and done are visible in the same cycle, and in_ready is already 1 in that cycle.
- Latency and throughput:
  - First valid bit appears the cycle after the accept edge.
  - An unstalled transaction occupies exactly INPUT_WIDTH consecutive bit_valid cycles.
  - Back-to-back: an accept in the done cycle yields the next stream's first bit on the following cycle, with zero bubbles.
- IDLE, or any non-emitting cycle: bit_valid=0, done=0. bit_out is 0 outside EMIT.
- Stall asserted in IDLE has no effect.
- Stall asserted on the final bit delays both that bit and done until stall drops.
- in_value=0 gives 32 zeros; in_value ≥ INPUT_WIDTH gives all ones, in both modes.
- Reset asserted mid-EMIT aborts the stream immediately (asynchronous). No done is issued, and all outputs return to reset values.

Decomposition:
- Shared package unary_pkg:
  - enum unary_mode_e {UNARY_THERM, UNARY_DIST}.
  - enum enc_state_e {ENC_IDLE, ENC_EMIT}.
  - The COUNT_WIDTH derivation convention.
- Optional single sub-module unary_bit_gen. It is the combinational next-bit/next-acc function for the two modes, reusable by a future stochastic/unary testbench source.
- FSM, counter and handshake stay in unary_stream_encoder.

Test Plan:
- Thermometer, in_value=5, no stall -> bits 1×5 then 0×27; bit_valid high 32 consecutive cycles starting 1 cycle after accept; done only on the 32nd.
- Distributed, in_value=16 -> pattern 0,1 repeated (16 ones); in_value=8 -> a 1 at every 4th bit (indices 3,7,...); ones after k bits == floor(k*val/32) checked every cycle.
- stall high for 3 cycles after bit 10, and again on bit 31 -> bit_valid low exactly during stall; sequence unchanged; done delayed to coincide with the final valid bit.
- in_value=0 and in_value=40 (saturation), both modes -> 32 zeros and 32 ones respectively.
- Back-to-back: in_valid held high with values 12 then 20 -> second stream's first bit immediately follows the first done; 64 contiguous valid bits.
- Reset low mid-stream at bit 17 -> outputs 0 asynchronously; after release in_ready=1, no done seen; a new transaction with value 3 runs cleanly from index 0.
